uart_rx_param: RTL and testbench

- Parametrised UART receiver that replaces the fixed 8-bit, one-clock-per-bit receive path feeding the LED / 7-segment display logic in top.
- Configurable bit period, data width, bit order, parity and stop-bit count.
- Received words are presented through a one-entry valid/ready output buffer, with frame, parity and overrun error reporting.

---
 rtl/uart_rx_param.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_param                                                |
// | Description : Parametrised UART receiver with parity/frame/overrun flags   |
// |               and a one-entry valid/ready output buffer.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int c_HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int c_BCW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_NW   = $clog2(DATA_BITS);

    localparam logic [c_BCW-1:0] c_BC_HALF   = c_BCW'(c_HALF);
    localparam logic [c_BCW-1:0] c_BC_LAST   = c_BCW'(CLKS_PER_BIT - 1);
    localparam logic [c_BCW-1:0] c_BC_ONE    = c_BCW'(1);
    localparam logic [c_NW-1:0]  c_LAST_DATA = c_NW'(DATA_BITS - 1);
    localparam logic [c_NW-1:0]  c_LAST_STOP = c_NW'(STOP_BITS - 1);
    localparam logic             c_PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;
    localparam logic [2:0] c_BREAK  = 3'd5;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [c_BCW-1:0]     r_bc;
    logic [c_NW-1:0]      r_nbit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;

    logic                 w_sample;
    logic                 w_bit_end;
    logic [c_BCW-1:0]     w_bc_next;
    logic                 w_complete;

    assign w_sample   = (r_bc == c_BC_HALF);
    assign w_bit_end  = (r_bc == c_BC_LAST);
    assign w_bc_next  = w_bit_end ? '0 : r_bc + c_BC_ONE;
    assign w_complete = (r_state == c_STOP) && w_sample && (r_nbit == c_LAST_STOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_bc      <= '0;
            r_nbit    <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_bc   <= '0;
                    r_nbit <= '0;
                    if (!r_rx_s) begin
                        r_par_err <= 1'b0;
                        r_frm_err <= 1'b0;
                        // The detection cycle is cycle 0 of the start bit.
                        if (CLKS_PER_BIT == 1) begin
                            r_state <= c_DATA;
                        end else begin
                            r_state <= c_START;
                            r_bc    <= c_BC_ONE;
                        end
                    end
                end
                c_START: begin
                    r_bc <= w_bc_next;
                    if (w_sample && r_rx_s) begin
                        r_state <= c_IDLE;
                        r_bc    <= '0;
                    end else if (w_bit_end) begin
                        r_state <= c_DATA;
                    end
                end
                c_DATA: begin
                    r_bc <= w_bc_next;
                    if (w_sample) begin
                        if (MSB_FIRST != 0)
                            r_shift <= {r_shift[DATA_BITS-2:0], r_rx_s};
                        else
                            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_bit_end) begin
                        if (r_nbit == c_LAST_DATA) begin
                            r_nbit  <= '0;
                            r_state <= (PARITY_EN != 0) ? c_PARITY : c_STOP;
                        end else begin
                            r_nbit <= r_nbit + 1'b1;
                        end
                    end
                end
                c_PARITY: begin
                    r_bc <= w_bc_next;
                    if (w_sample)
                        r_par_err <= (^r_shift) ^ r_rx_s ^ c_PAR_ODD;
                    if (w_bit_end)
                        r_state <= c_STOP;
                end
                c_STOP: begin
                    r_bc <= w_bc_next;
                    if (w_sample && !r_rx_s)
                        r_frm_err <= 1'b1;
                    // Frame ends at the last stop sample so back-to-back frames fit.
                    if (w_complete) begin
                        r_bc    <= '0;
                        r_nbit  <= '0;
                        r_state <= r_rx_s ? c_IDLE : c_BREAK;
                    end else if (w_bit_end) begin
                        r_nbit <= r_nbit + 1'b1;
                    end
                end
                c_BREAK: begin
                    r_bc <= '0;
                    if (r_rx_s)
                        r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_bc    <= '0;
                    r_nbit  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (w_complete) begin
                if (!data_valid || data_ready) begin
                    data_out   <= r_shift;
                    frame_err  <= r_frm_err | ~r_rx_s;
                    parity_err <= r_par_err;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_param                                             |
// | Description : Self-checking bench for uart_rx_param, three configurations.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
    logic [7:0] dout_a, dout_b, dout_c;
    logic valid_a, valid_b, valid_c;
    logic fe_a, fe_b, fe_c, pe_a, pe_b, pe_c, ov_a, ov_b, ov_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] got_a[$], got_b[$], got_c[$];
    logic [9:0] exp_q[$];
    int valid_cycles_a = 0;
    int ov_cycles_c = 0;
    bit tx_bits[$];

    uart_rx_param #(.CLKS_PER_BIT(1)) u_a (
        .clk(clk), .reset(reset), .rx(rx_a), .data_out(dout_a), .data_valid(valid_a),
        .data_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

    uart_rx_param #(.CLKS_PER_BIT(16), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clk(clk), .reset(reset), .rx(rx_b), .data_out(dout_b), .data_valid(valid_b),
        .data_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

    uart_rx_param #(.CLKS_PER_BIT(16)) u_c (
        .clk(clk), .reset(reset), .rx(rx_c), .data_out(dout_c), .data_valid(valid_c),
        .data_ready(rdy_c), .frame_err(fe_c), .parity_err(pe_c), .overrun(ov_c));

    // Handshakes are recorded with the values present just before each edge.
    always @(posedge clk) begin
        if (valid_a && rdy_a) got_a.push_back({fe_a, pe_a, dout_a});
        if (valid_b && rdy_b) got_b.push_back({fe_b, pe_b, dout_b});
        if (valid_c && rdy_c) got_c.push_back({fe_c, pe_c, dout_c});
        if (valid_a) valid_cycles_a++;
        if (ov_c) ov_cycles_c++;
    end

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Line-level picture of a frame: start, data in wire order, optional parity, stop.
    task automatic build_frame(input logic [7:0] d, input bit msb, input bit par_en,
                               input bit par_bit, input bit stop_v);
        tx_bits.delete();
        tx_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_bits.push_back(msb ? d[7-i] : d[i]);
        if (par_en) tx_bits.push_back(par_bit);
        tx_bits.push_back(stop_v);
    endtask

    task automatic drive_bits(input int sel, input int cpb);
        foreach (tx_bits[i]) begin
            set_rx(sel, tx_bits[i]);
            repeat (cpb) @(negedge clk);
        end
    endtask

    function automatic logic [9:0] model_word(input logic [7:0] d, input bit par_en,
                                              input bit odd, input bit par_bit, input bit stop_v);
        bit pe;
        pe = par_en && ((($countones(d) + int'(par_bit)) % 2) != (odd ? 1 : 0));
        return {~stop_v, pe, d};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dout_a, valid_a, fe_a, pe_a, ov_a} !== 12'h0) begin
            n_fail++; $display("FAIL reset_a: got %h expected 000", {dout_a, valid_a, fe_a, pe_a, ov_a});
        end
        n_checks++;
        if ({dout_b, valid_b, fe_b, pe_b, ov_b} !== 12'h0) begin
            n_fail++; $display("FAIL reset_b: got %h expected 000", {dout_b, valid_b, fe_b, pe_b, ov_b});
        end
        n_checks++;
        if ({dout_c, valid_c, fe_c, pe_c, ov_c} !== 12'h0) begin
            n_fail++; $display("FAIL reset_c: got %h expected 000", {dout_c, valid_c, fe_c, pe_c, ov_c});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_fast;
        got_a.delete();
        valid_cycles_a = 0;
        rdy_a = 1'b1;
        @(negedge clk);
        build_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bits(0, 1);
        @(negedge clk);
        n_checks++;
        if (valid_a !== 1'b0) begin
            n_fail++; $display("FAIL fast_latency_early: valid %b expected 0", valid_a);
        end
        @(negedge clk);
        n_checks++;
        if ({valid_a, fe_a, pe_a, dout_a} !== {3'b100, 8'hA5}) begin
            n_fail++; $display("FAIL fast_a5: got %h expected %h", {valid_a, fe_a, pe_a, dout_a}, {3'b100, 8'hA5});
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (valid_cycles_a != 1 || got_a.size() != 1) begin
            n_fail++; $display("FAIL fast_valid_width: cycles %0d words %0d expected 1 1", valid_cycles_a, got_a.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        got_a.delete();
        exp_q.delete();
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            exp_q.push_back(model_word(d, 1'b0, 1'b0, 1'b0, 1'b1));
            build_frame(d, 1'b1, 1'b0, 1'b0, 1'b1);
            drive_bits(0, 1);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (got_a.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got_a.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_a.size(); k++) begin
            n_checks++;
            if (got_a[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", k, got_a[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_parity;
        logic [7:0] d;
        bit p;
        got_b.delete();
        exp_q.delete();
        rdy_b = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            d = (k < 2) ? 8'h3C : 8'($urandom);
            p = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : 1'($urandom);
            exp_q.push_back(model_word(d, 1'b1, 1'b0, p, 1'b1));
            build_frame(d, 1'b0, 1'b1, p, 1'b1);
            drive_bits(1, 16);
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (got_b.size() != exp_q.size()) begin
            n_fail++; $display("FAIL parity_count: got %0d expected %0d", got_b.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_b.size(); k++) begin
            n_checks++;
            if (got_b[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL parity_word%0d: got %h expected %h", k, got_b[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_break;
        logic [7:0] d;
        got_c.delete();
        rdy_c = 1'b1;
        d = 8'($urandom);
        @(negedge clk);
        build_frame(d, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_bits(2, 16);
        repeat (24) @(negedge clk);
        set_rx(2, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (got_c.size() != 1 || got_c[0] !== model_word(d, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL break_frame: words %0d first %h expected 1 %h", got_c.size(),
                               (got_c.size() > 0) ? got_c[0] : 10'h0, model_word(d, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        build_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bits(2, 16);
        repeat (20) @(negedge clk);
        n_checks++;
        if (got_c.size() != 2 || got_c[got_c.size()-1] !== {2'b00, 8'h81}) begin
            n_fail++; $display("FAIL break_recover: words %0d last %h expected 2 %h", got_c.size(),
                               (got_c.size() > 0) ? got_c[got_c.size()-1] : 10'h0, {2'b00, 8'h81});
        end
    endtask

    task automatic test_glitch;
        logic [7:0] d;
        got_c.delete();
        @(negedge clk);
        set_rx(2, 1'b0);
        repeat (4) @(negedge clk);
        set_rx(2, 1'b1);
        repeat (60) @(negedge clk);
        n_checks++;
        if (got_c.size() != 0 || valid_c !== 1'b0) begin
            n_fail++; $display("FAIL glitch_quiet: words %0d valid %b expected 0 0", got_c.size(), valid_c);
        end
        d = 8'($urandom);
        build_frame(d, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bits(2, 16);
        repeat (20) @(negedge clk);
        n_checks++;
        if (got_c.size() != 1 || got_c[0] !== model_word(d, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_fail++; $display("FAIL glitch_after: words %0d first %h expected 1 %h", got_c.size(),
                               (got_c.size() > 0) ? got_c[0] : 10'h0, model_word(d, 1'b0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_overrun;
        got_c.delete();
        rdy_c = 1'b0;
        ov_cycles_c = 0;
        @(negedge clk);
        build_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bits(2, 16);
        repeat (4) @(negedge clk);
        build_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bits(2, 16);
        repeat (20) @(negedge clk);
        n_checks++;
        if ({valid_c, dout_c} !== {1'b1, 8'h11}) begin
            n_fail++; $display("FAIL overrun_hold: got %h expected %h", {valid_c, dout_c}, {1'b1, 8'h11});
        end
        n_checks++;
        if (ov_cycles_c != 1) begin
            n_fail++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ov_cycles_c);
        end
        rdy_c = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid_c !== 1'b0) begin
            n_fail++; $display("FAIL overrun_release: valid %b expected 0", valid_c);
        end
        n_checks++;
        if (got_c.size() != 1 || got_c[0] !== {2'b00, 8'h11}) begin
            n_fail++; $display("FAIL overrun_word: words %0d first %h expected 1 %h", got_c.size(),
                               (got_c.size() > 0) ? got_c[0] : 10'h0, {2'b00, 8'h11});
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        rdy_c = 1'b0;
        d = 8'($urandom) | 8'h01;
        @(negedge clk);
        build_frame(d, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bits(2, 16);
        repeat (20) @(negedge clk);
        n_checks++;
        if ({valid_c, dout_c} !== {1'b1, d}) begin
            n_fail++; $display("FAIL midreset_pre: got %h expected %h", {valid_c, dout_c}, {1'b1, d});
        end
        // Start of 0xFF, then cut into its 4th data bit.
        set_rx(2, 1'b0);
        repeat (16) @(negedge clk);
        set_rx(2, 1'b1);
        repeat (3 * 16 + 8) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({dout_c, valid_c, fe_c, pe_c, ov_c} !== 12'h0) begin
            n_fail++; $display("FAIL midreset_async: got %h expected 000", {dout_c, valid_c, fe_c, pe_c, ov_c});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rdy_c = 1'b1;
        got_c.delete();
        repeat (40) @(negedge clk);
        build_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bits(2, 16);
        repeat (20) @(negedge clk);
        n_checks++;
        if (got_c.size() != 1 || got_c[0] !== {2'b00, 8'h5A}) begin
            n_fail++; $display("FAIL midreset_after: words %0d first %h expected 1 %h", got_c.size(),
                               (got_c.size() > 0) ? got_c[0] : 10'h0, {2'b00, 8'h5A});
        end
    endtask

    initial begin
        test_reset();
        test_basic_fast();
        test_back_to_back();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
